// File: rtl/printer_preheat_if.sv
// Panel/axis/heater signal bundle for the preheat sequencer.
// With PREHEAT_THERMAL_CHECK_EN defined, the bundle also carries temp_ok.
interface printer_preheat_if #(
  parameter int unsigned N_AXES = 3
) ();

  logic              start_btn;
  logic              abort;
  logic [1:0]        mat_sel;
  logic [N_AXES-1:0] home_sw;
`ifdef PREHEAT_THERMAL_CHECK_EN
  logic              temp_ok;
`endif
  logic [N_AXES-1:0] motor_en;
  logic              heat_bed;
  logic              heat_end;
  logic              busy;
  logic              ready;
  logic              error;
  logic [1:0]        err_code;
  logic [2:0]        state_o;

`ifdef PREHEAT_THERMAL_CHECK_EN
  modport master (
    output start_btn, abort, mat_sel, home_sw, temp_ok,
    input  motor_en, heat_bed, heat_end, busy, ready, error, err_code, state_o
  );

  modport slave (
    input  start_btn, abort, mat_sel, home_sw, temp_ok,
    output motor_en, heat_bed, heat_end, busy, ready, error, err_code, state_o
  );
`else
  modport master (
    output start_btn, abort, mat_sel, home_sw,
    input  motor_en, heat_bed, heat_end, busy, ready, error, err_code, state_o
  );

  modport slave (
    input  start_btn, abort, mat_sel, home_sw,
    output motor_en, heat_bed, heat_end, busy, ready, error, err_code, state_o
  );
`endif

endinterface

// File: rtl/printer_preheat_ctrl.sv
// Pre-print sequencer: debounced start, axis homing, timed bed/hotend preheat.
// Optional PREHEAT_THERMAL_CHECK_EN gates HEAT_END exit and READY on temp_ok.
module printer_preheat_ctrl #(
  parameter int unsigned N_AXES     = 3,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned T_W        = 16,
  parameter int unsigned T_BED      = 20,
  parameter int unsigned T_PLA      = 8,
  parameter int unsigned T_ABS      = 10,
  parameter int unsigned T_TPU      = 8,
  parameter int unsigned HOME_TO    = 64
) (
  input logic              clk,
  input logic              reset,
  printer_preheat_if.slave bus
);

  localparam int unsigned IDX_W = (N_AXES > 1) ? $clog2(N_AXES) : 1;
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_AXES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [T_W-1:0]   HOME_LAST = T_W'(HOME_TO - 1);
  localparam logic [T_W-1:0]   BED_LAST  = T_W'(T_BED - 1);
  localparam logic [T_W-1:0]   PLA_LAST  = T_W'(T_PLA - 1);
  localparam logic [T_W-1:0]   ABS_LAST  = T_W'(T_ABS - 1);
  localparam logic [T_W-1:0]   TPU_LAST  = T_W'(T_TPU - 1);
`ifdef PREHEAT_THERMAL_CHECK_EN
  localparam logic [T_W-1:0]   PLA_LIM   = T_W'(2 * T_PLA - 1);
  localparam logic [T_W-1:0]   ABS_LIM   = T_W'(2 * T_ABS - 1);
  localparam logic [T_W-1:0]   TPU_LIM   = T_W'(2 * T_TPU - 1);
`endif

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StHoming  = 3'd1,
    StHeatBed = 3'd2,
    StHeatEnd = 3'd3,
    StReady   = 3'd4,
    StError   = 3'd5
  } state_e;

  // Start button synchroniser and debouncer
  logic             sync1_q, sync2_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             fired_q;
  logic             start_p_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_cnt_q <= '0;
      fired_q   <= 1'b0;
      start_p_q <= 1'b0;
    end else begin
      sync1_q <= bus.start_btn;
      sync2_q <= sync1_q;
      if (!sync2_q) begin
        deb_cnt_q <= '0;
        fired_q   <= 1'b0;
        start_p_q <= 1'b0;
      end else if (!fired_q && (deb_cnt_q == DEB_LAST)) begin
        deb_cnt_q <= '0;
        fired_q   <= 1'b1;
        start_p_q <= 1'b1;
      end else begin
        start_p_q <= 1'b0;
        if (!fired_q) begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end
    end
  end

  // Sequencer state
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [T_W-1:0]    timer_q, timer_d;
  logic [1:0]        mat_q, mat_d;
  logic [1:0]        err_q, err_d;
  logic [N_AXES-1:0] motor_en_q;
  logic              heat_bed_q, heat_end_q, busy_q, ready_q, error_q;
  logic [T_W-1:0]    mat_last;
`ifdef PREHEAT_THERMAL_CHECK_EN
  logic              temp_low_q, temp_low_d;
  logic [T_W-1:0]    mat_limit;
`endif

  always_comb begin
    case (mat_q)
      2'b10:   mat_last = ABS_LAST;
      2'b11:   mat_last = TPU_LAST;
      default: mat_last = PLA_LAST;
    endcase
  end

`ifdef PREHEAT_THERMAL_CHECK_EN
  always_comb begin
    case (mat_q)
      2'b10:   mat_limit = ABS_LIM;
      2'b11:   mat_limit = TPU_LIM;
      default: mat_limit = PLA_LIM;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    mat_d   = mat_q;
    err_d   = err_q;
`ifdef PREHEAT_THERMAL_CHECK_EN
    temp_low_d = 1'b0;
`endif
    if (bus.abort) begin
      state_d = StIdle;
      idx_d   = '0;
      err_d   = 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_p_q) begin
            if (bus.mat_sel != 2'b00) begin
              state_d = StHoming;
              mat_d   = bus.mat_sel;
              idx_d   = '0;
            end else begin
              state_d = StError;
              err_d   = 2'b01;
            end
          end
        end
        StHoming: begin
          // Switch high on the timeout cycle still counts as homed
          if (bus.home_sw[idx_q]) begin
            timer_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = StHeatBed;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (timer_q == HOME_LAST) begin
            state_d = StError;
            err_d   = 2'b10;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StHeatBed: begin
          if (timer_q == BED_LAST) begin
            state_d = StHeatEnd;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StHeatEnd: begin
`ifdef PREHEAT_THERMAL_CHECK_EN
          if ((timer_q >= mat_last) && bus.temp_ok) begin
            state_d = StReady;
          end else if (timer_q == mat_limit) begin
            state_d = StError;
            err_d   = 2'b11;
          end else begin
            timer_d = timer_q + 1'b1;
          end
`else
          if (timer_q == mat_last) begin
            state_d = StReady;
          end else begin
            timer_d = timer_q + 1'b1;
          end
`endif
        end
        StReady: begin
`ifdef PREHEAT_THERMAL_CHECK_EN
          if (!bus.temp_ok) begin
            if (temp_low_q) begin
              state_d = StError;
              err_d   = 2'b11;
            end else begin
              temp_low_d = 1'b1;
            end
          end
`endif
        end
        StError: begin
        end
        default: state_d = StIdle;
      endcase
    end
    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the entering edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      timer_q    <= '0;
      mat_q      <= 2'b00;
      err_q      <= 2'b00;
      motor_en_q <= '0;
      heat_bed_q <= 1'b0;
      heat_end_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
`ifdef PREHEAT_THERMAL_CHECK_EN
      temp_low_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      mat_q      <= mat_d;
      err_q      <= err_d;
      motor_en_q <= (state_d == StHoming) ? (N_AXES'(1) << idx_d) : '0;
      heat_bed_q <= state_d inside {StHeatBed, StHeatEnd, StReady};
      heat_end_q <= state_d inside {StHeatEnd, StReady};
      busy_q     <= state_d inside {StHoming, StHeatBed, StHeatEnd};
      ready_q    <= (state_d == StReady);
      error_q    <= (state_d == StError);
`ifdef PREHEAT_THERMAL_CHECK_EN
      temp_low_q <= temp_low_d;
`endif
    end
  end

  assign bus.motor_en = motor_en_q;
  assign bus.heat_bed = heat_bed_q;
  assign bus.heat_end = heat_end_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.error    = error_q;
  assign bus.err_code = err_q;
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_printer_preheat_ctrl.sv
// Scoreboard bench for printer_preheat_ctrl: stimulus queues expected output
// events with their cycle; a monitor compares every change of the outputs.
module tb_printer_preheat_ctrl;

  localparam int unsigned NA      = 3;
  localparam int          DEB     = 4;
  localparam int          T_BED   = 20;
  localparam int          T_PLA   = 8;
  localparam int          T_ABS   = 10;
  localparam int          T_TPU   = 8;
  localparam int          HOME_TO = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   last_change = 0;

  typedef struct {
    logic [12:0] snap;
    int          at;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  printer_preheat_if #(.N_AXES(NA)) bus ();

  printer_preheat_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {state, motor_en, heat_bed, heat_end, busy, ready, error, err_code}
  function automatic logic [12:0] mk(input logic [2:0] st, input logic [2:0] mot,
                                     input logic [1:0] ec);
    logic hb, he, by, rd, er;
    hb = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
    he = (st == 3'd3) || (st == 3'd4);
    by = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
    rd = (st == 3'd4);
    er = (st == 3'd5);
    return {st, mot, hb, he, by, rd, er, ec};
  endfunction

  function automatic logic [12:0] snap();
    return {bus.state_o, bus.motor_en, bus.heat_bed, bus.heat_end, bus.busy, bus.ready,
            bus.error, bus.err_code};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input string name, input logic [2:0] st, input logic [2:0] mot,
                           input logic [1:0] ec, input int at);
    exp_t e;
    e.snap = mk(st, mot, ec);
    e.at   = at;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [12:0] want);
    logic [12:0] got;
    got = snap();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: outputs %h, required %h", name, got, want);
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step(1);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d events (next %s) pending after %0d cycles, required 0",
               exp_q.size(), exp_q[0].name, max);
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int max);
    int n;
    n = 0;
    while (bus.state_o != st && n < max) begin
      step(1);
      n++;
    end
    vectors++;
    if (bus.state_o != st) begin
      miscompares++;
      $display("FAIL wait_state: state_o %0d after %0d cycles, required %0d", bus.state_o,
               max, st);
    end
  endtask

  task automatic abort_to_idle(input string name);
    bus.abort = 1'b1;
    expect_ev(name, 3'd0, 3'b000, 2'b00, cyc + 1);
    step(1);
    bus.abort = 1'b0;
    drain(5);
  endtask

  // Drives each switch 5 cycles after its motor; fail_axis never reports home.
  task automatic do_homing(input int fail_axis, output int hb_cyc);
    hb_cyc = -1;
    for (int i = 0; i < int'(NA); i++) begin
      drain(100);
      if (i == fail_axis) begin
        expect_ev("home_timeout", 3'd5, 3'b000, 2'b10, last_change + HOME_TO);
        return;
      end
      step(5);
      bus.home_sw[i] = 1'b1;
      if (i < int'(NA) - 1) begin
        expect_ev("axis_advance", 3'd1, 3'(1 << (i + 1)), 2'b00, cyc + 1);
      end else begin
        hb_cyc = cyc + 1;
        expect_ev("enter_heat_bed", 3'd2, 3'b000, 2'b00, hb_cyc);
      end
    end
  endtask

  task automatic rearm(input logic [1:0] mat);
    bus.start_btn = 1'b0;
    bus.home_sw   = '0;
    step(4);
    bus.mat_sel   = mat;
    bus.start_btn = 1'b1;
  endtask

  initial begin : monitor
    logic [12:0] prev, cur;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = snap();
      if (cur !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change: outputs %h at cycle %0d, required %h unchanged",
                   cur, cyc, prev);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.snap || (e.at >= 0 && cyc != e.at)) begin
            miscompares++;
            $display("FAIL %s: outputs %h at cycle %0d, required %h at cycle %0d", e.name,
                     cur, cyc, e.snap, e.at);
          end
        end
        prev        = cur;
        last_change = cyc;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int hb;
    bus.start_btn = 1'b0;
    bus.abort     = 1'b0;
    bus.mat_sel   = 2'b00;
    bus.home_sw   = '0;
`ifdef PREHEAT_THERMAL_CHECK_EN
    bus.temp_ok   = 1'b1;
`endif
    step(3);
    reset = 1'b0;
    step(3);
    check_now("reset_state", mk(3'd0, 3'b000, 2'b00));

    // Bounce 1-0-1 then hold; PLA full run
    bus.mat_sel   = 2'b01;
    bus.start_btn = 1'b1;
    step(1);
    bus.start_btn = 1'b0;
    step(1);
    bus.start_btn = 1'b1;
    expect_ev("debounced_start_pla", 3'd1, 3'b001, 2'b00, cyc + 3 + DEB);
    do_homing(-1, hb);
    expect_ev("enter_heat_end_pla", 3'd3, 3'b000, 2'b00, hb + T_BED);
    expect_ev("ready_pla", 3'd4, 3'b000, 2'b00, hb + T_BED + T_PLA);
    drain(100);
    step(10);
    abort_to_idle("abort_from_ready");
    step(20);
    check_now("no_second_pulse_while_held", mk(3'd0, 3'b000, 2'b00));

    // ABS; material change during HEAT_END is ignored
    rearm(2'b10);
    expect_ev("start_abs", 3'd1, 3'b001, 2'b00, cyc + 3 + DEB);
    do_homing(-1, hb);
    expect_ev("enter_heat_end_abs", 3'd3, 3'b000, 2'b00, hb + T_BED);
    expect_ev("ready_abs_ignores_mat_change", 3'd4, 3'b000, 2'b00, hb + T_BED + T_ABS);
    wait_state(3'd3, 100);
    step(3);
    bus.mat_sel = 2'b11;
    drain(100);
    abort_to_idle("abort_after_abs");

    // Axis 1 never homes
    rearm(2'b01);
    expect_ev("start_for_timeout", 3'd1, 3'b001, 2'b00, cyc + 3 + DEB);
    do_homing(1, hb);
    drain(100);
    step(5);
    abort_to_idle("abort_clears_home_timeout");

    // No material selected
    rearm(2'b00);
    expect_ev("bad_material", 3'd5, 3'b000, 2'b01, cyc + 3 + DEB);
    drain(30);
    step(5);
    abort_to_idle("abort_clears_bad_material");

    // TPU, abort in the middle of HEAT_END
    rearm(2'b11);
    expect_ev("start_tpu", 3'd1, 3'b001, 2'b00, cyc + 3 + DEB);
    do_homing(-1, hb);
    expect_ev("enter_heat_end_tpu", 3'd3, 3'b000, 2'b00, hb + T_BED);
    drain(100);
    step(3);
    abort_to_idle("abort_mid_heat_end");

    // Asynchronous reset while homing
    rearm(2'b01);
    expect_ev("start_before_reset", 3'd1, 3'b001, 2'b00, cyc + 3 + DEB);
    drain(30);
    step(2);
    bus.start_btn = 1'b0;
    @(negedge clk);
    #2;
    expect_ev("reset_in_homing", 3'd0, 3'b000, 2'b00, cyc + 1);
    reset = 1'b1;
    #1;
    check_now("reset_drops_outputs_async", mk(3'd0, 3'b000, 2'b00));
    step(2);
    reset = 1'b0;
    step(5);
    drain(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
